// File: rtl/heichips25_proj_sel_pkg.sv
// rtl/heichips25_proj_sel_pkg.sv - shared types and helpers for the project select controller
package heichips25_proj_sel_pkg;

  // Controller phases: RUN owns the pads, GATE isolates them, RESET holds the new project in reset
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATE  = 2'd1,
    ST_RESET = 2'd2
  } state_t;

  // Width of the shared phase counter: must hold the larger of the two window lengths
  function automatic int cnt_width(input int guard_cycles, input int rst_cycles);
    int m;
    m = (guard_cycles > rst_cycles) ? guard_cycles : rst_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/heichips25_cycle_timer.sv
// rtl/heichips25_cycle_timer.sv - loadable down-counter with done flag
module heichips25_cycle_timer #(
  parameter int CNT_W   = 4,
  parameter int RST_VAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] r_count;

  // Count down to zero and stop there; a load always restarts the window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= CNT_W'(RST_VAL);
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Done on the last cycle of the window so the owner can switch phase on the next edge
  assign done = (r_count <= CNT_W'(1));

endmodule

// File: rtl/heichips25_proj_sel_ctrl.sv
// rtl/heichips25_proj_sel_ctrl.sv - pad sharing controller; optional HEICHIPS25_PROJ_SEL_LOCK_EN adds sel_lock
module heichips25_proj_sel_ctrl
  import heichips25_proj_sel_pkg::*;
#(
  parameter  int NUM_PROJ     = 2,
  parameter  int GUARD_CYCLES = 4,
  parameter  int RST_CYCLES   = 8,
  localparam int SEL_W        = $clog2(NUM_PROJ)
) (
  input  logic                clk,
  input  logic                rst,
`ifdef HEICHIPS25_PROJ_SEL_LOCK_EN
  input  logic                sel_lock,
`endif
  input  logic                sel_req_valid,
  input  logic [SEL_W-1:0]    sel_req_id,
  output logic                sel_req_ready,
  output logic [NUM_PROJ-1:0] proj_ena,
  output logic [NUM_PROJ-1:0] proj_rst_n,
  output logic [SEL_W-1:0]    active_id,
  output logic                out_en,
  output logic                busy,
  output logic                err_bad_id
);

  localparam int               CNT_W    = cnt_width(GUARD_CYCLES, RST_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYCLES);

  state_t                r_state;
  logic [SEL_W-1:0]      r_active_id;
  logic [SEL_W-1:0]      r_next_id;
  logic [NUM_PROJ-1:0]   r_ena;
  logic [NUM_PROJ-1:0]   r_rst_n;
  logic                  r_out_en;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_err;

  logic                  w_lock;
  logic                  w_accept;
  logic                  w_id_ok;
  logic                  w_done;
  logic                  w_timer_load;
  logic [CNT_W-1:0]      w_timer_val;

`ifdef HEICHIPS25_PROJ_SEL_LOCK_EN
  // Lock is sampled into the registered ready, so it takes effect from the next cycle
  assign w_lock = sel_lock;
`else
  assign w_lock = 1'b0;
`endif

  function automatic logic [NUM_PROJ-1:0] onehot(input logic [SEL_W-1:0] id);
    return NUM_PROJ'(1) << id;
  endfunction

  assign w_accept     = sel_req_valid && r_ready && (r_state == ST_RUN);
  assign w_id_ok      = int'(sel_req_id) < NUM_PROJ;
  assign w_timer_load = (w_accept && w_id_ok) || ((r_state == ST_GATE) && w_done);
  assign w_timer_val  = (r_state == ST_RUN) ? GUARD_LD : RST_LD;

  heichips25_cycle_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (RST_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_timer_load),
    .load_val (w_timer_val),
    .done     (w_done)
  );

  // Phase sequencing with every output registered; the pad mux only changes while gated
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RESET;
      r_active_id <= '0;
      r_next_id   <= '0;
      r_ena       <= NUM_PROJ'(1);
      r_rst_n     <= '0;
      r_out_en    <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_ready <= ~w_lock;
          if (w_accept) begin
            if (w_id_ok) begin
              r_state   <= ST_GATE;
              r_next_id <= sel_req_id;
              r_ena     <= '0;
              r_rst_n   <= '0;
              r_out_en  <= 1'b0;
              r_ready   <= 1'b0;
              r_busy    <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_GATE: begin
          if (w_done) begin
            r_state     <= ST_RESET;
            r_active_id <= r_next_id;
            r_ena       <= onehot(r_next_id);
          end
        end
        ST_RESET: begin
          if (w_done) begin
            r_state  <= ST_RUN;
            r_rst_n  <= onehot(r_active_id);
            r_out_en <= 1'b1;
            r_ready  <= ~w_lock;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_RESET;
          r_ena    <= onehot(r_active_id);
          r_rst_n  <= '0;
          r_out_en <= 1'b0;
          r_ready  <= 1'b0;
          r_busy   <= 1'b1;
        end
      endcase
    end
  end

  assign sel_req_ready = r_ready;
  assign proj_ena      = r_ena;
  assign proj_rst_n    = r_rst_n;
  assign active_id     = r_active_id;
  assign out_en        = r_out_en;
  assign busy          = r_busy;
  assign err_bad_id    = r_err;

endmodule

// File: tb/tb_heichips25_proj_sel_ctrl.sv
// tb/tb_heichips25_proj_sel_ctrl.sv - scoreboard bench for heichips25_proj_sel_ctrl (NUM_PROJ=3)
module tb_heichips25_proj_sel_ctrl;

  localparam int NP    = 3;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sel_req_valid = 1'b0;
  logic [SEL_W-1:0] sel_req_id = '0;
`ifdef HEICHIPS25_PROJ_SEL_LOCK_EN
  logic             sel_lock = 1'b0;
`endif
  logic             sel_req_ready;
  logic [NP-1:0]    proj_ena;
  logic [NP-1:0]    proj_rst_n;
  logic [SEL_W-1:0] active_id;
  logic             out_en;
  logic             busy;
  logic             err_bad_id;

  int               n_checks = 0;
  int               n_fail   = 0;
  string            cur_tag  = "init";
  logic [11:0]      exp_q[$];

  always #5 clk = ~clk;

  heichips25_proj_sel_ctrl #(
    .NUM_PROJ     (NP),
    .GUARD_CYCLES (4),
    .RST_CYCLES   (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef HEICHIPS25_PROJ_SEL_LOCK_EN
    .sel_lock      (sel_lock),
`endif
    .sel_req_valid (sel_req_valid),
    .sel_req_id    (sel_req_id),
    .sel_req_ready (sel_req_ready),
    .proj_ena      (proj_ena),
    .proj_rst_n    (proj_rst_n),
    .active_id     (active_id),
    .out_en        (out_en),
    .busy          (busy),
    .err_bad_id    (err_bad_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (busy,ready,oe,err,act[2],ena[3],rst_n[3])", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] oh(input logic [1:0] a);
    logic [2:0] v;
    v = 3'b001 << a;
    return v;
  endfunction

  // Packed view: {busy, ready, out_en, err, active_id[1:0], ena[2:0], rst_n[2:0]}
  function automatic logic [11:0] e_reset(input logic [1:0] a);
    return {1'b1, 1'b0, 1'b0, 1'b0, a, oh(a), 3'b000};
  endfunction
  function automatic logic [11:0] e_gate(input logic [1:0] a);
    return {1'b1, 1'b0, 1'b0, 1'b0, a, 3'b000, 3'b000};
  endfunction
  function automatic logic [11:0] e_run(input logic [1:0] a, input logic rdy);
    return {1'b0, rdy, 1'b1, 1'b0, a, oh(a), oh(a)};
  endfunction
  function automatic logic [11:0] e_bad(input logic [1:0] a);
    return {1'b0, 1'b1, 1'b1, 1'b1, a, oh(a), oh(a)};
  endfunction

  task automatic push(input int n, input logic [11:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // One clock: outputs are sampled on the falling edge and compared to the oldest expectation
  task automatic step();
    logic [11:0] obs;
    logic [11:0] e;
    @(posedge clk);
    @(negedge clk);
    obs = {busy, sel_req_ready, out_en, err_bad_id, active_id, proj_ena, proj_rst_n};
    if (exp_q.size() == 0) begin
      check_eq({cur_tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(cur_tag, {20'd0, obs}, {20'd0, e});
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset held two edges, then an eight-cycle reset window on project 0
    cur_tag = "reset";
    push(2, e_reset(2'd0));
    run_n(2);
    rst = 1'b0;
    cur_tag = "rst_window";
    push(7, e_reset(2'd0));
    push(3, e_run(2'd0, 1'b1));
    run_n(10);

    // Switch 0 -> 1: 4 gated cycles, 8 reset cycles on the new project, then run
    cur_tag = "switch_to_1";
    sel_req_valid = 1'b1;
    sel_req_id    = 2'd1;
    push(4, e_gate(2'd0));
    push(8, e_reset(2'd1));
    push(3, e_run(2'd1, 1'b1));
    step();
    sel_req_valid = 1'b0;
    run_n(14);

    // Restart of the active project; a request held while busy must be ignored
    cur_tag = "restart_1";
    sel_req_valid = 1'b1;
    sel_req_id    = 2'd1;
    push(4, e_gate(2'd1));
    push(8, e_reset(2'd1));
    push(3, e_run(2'd1, 1'b1));
    step();
    sel_req_id = 2'd2;
    run_n(9);
    sel_req_valid = 1'b0;
    run_n(5);

    // Out-of-range id: single error pulse, nothing else moves
    cur_tag = "bad_id";
    sel_req_valid = 1'b1;
    sel_req_id    = 2'd3;
    push(1, e_bad(2'd1));
    push(3, e_run(2'd1, 1'b1));
    step();
    sel_req_valid = 1'b0;
    run_n(3);

    // Reset during the gate window toward project 2 returns to project 0
    cur_tag = "rst_in_gate";
    sel_req_valid = 1'b1;
    sel_req_id    = 2'd2;
    push(2, e_gate(2'd1));
    step();
    sel_req_valid = 1'b0;
    step();
    rst = 1'b1;
    push(1, e_reset(2'd0));
    step();
    rst = 1'b0;
    push(7, e_reset(2'd0));
    push(2, e_run(2'd0, 1'b1));
    run_n(9);

`ifdef HEICHIPS25_PROJ_SEL_LOCK_EN
    // Locked: requests are refused for 20 cycles, accepted once the lock drops
    cur_tag = "lock";
    sel_lock = 1'b1;
    push(1, e_run(2'd0, 1'b0));
    step();
    sel_req_valid = 1'b1;
    sel_req_id    = 2'd1;
    push(20, e_run(2'd0, 1'b0));
    run_n(20);
    cur_tag = "unlock";
    sel_lock = 1'b0;
    push(1, e_run(2'd0, 1'b1));
    push(4, e_gate(2'd0));
    push(8, e_reset(2'd1));
    push(2, e_run(2'd1, 1'b1));
    run_n(2);
    sel_req_valid = 1'b0;
    run_n(13);
`endif

    check_eq("sb_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
